// File: rtl/cmpxchg_mem_seq_pkg.sv
// rtl/cmpxchg_mem_seq_pkg.sv - shared encodings and helpers for the memory-form CMPXCHG sequencer
package cmpxchg_mem_seq_pkg;

    localparam logic [1:0] SZ8  = 2'd0;
    localparam logic [1:0] SZ16 = 2'd1;
    localparam logic [1:0] SZ32 = 2'd2;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_AF = 2;
    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_CMP     = 3'd4;
    localparam logic [2:0] ST_WR_REQ  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CHECK   = ST_CHECK,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_WAIT = ST_RD_WAIT,
        S_CMP     = ST_CMP,
        S_WR_REQ  = ST_WR_REQ,
        S_DONE    = ST_DONE
    } state_t;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ8:     return 32'h0000_00ff;
            SZ16:    return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ8:     return 4'b0001 << off;
            SZ16:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Size 3 is illegal; wider operands must sit on their natural boundary.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ8:     return 1'b0;
            SZ16:    return off[0];
            SZ32:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cmpxchg_mem_seq_if.sv
// rtl/cmpxchg_mem_seq_if.sv - execute command, data-memory port and writeback result bundle
interface cmpxchg_mem_seq_if #(parameter int AW = 32);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_size;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_src;
    logic [31:0]   cmd_acc;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [3:0]    mem_req_be;
    logic [31:0]   mem_req_wdata;
    logic          mem_lock;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_rdata;

    logic          done_valid;
    logic [31:0]   acc_out;
    logic [5:0]    flags_out;
    logic          fault;

    modport slave (
        input  cmd_valid, cmd_size, cmd_addr, cmd_src, cmd_acc,
        output cmd_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata, mem_lock,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output done_valid, acc_out, flags_out, fault
    );

    modport master (
        output cmd_valid, cmd_size, cmd_addr, cmd_src, cmd_acc,
        input  cmd_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata, mem_lock,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  done_valid, acc_out, flags_out, fault
    );
endinterface

// File: rtl/cmpxchg_flag_calc.sv
// rtl/cmpxchg_flag_calc.sv - size-aware acc - dest subtract producing {OF,SF,ZF,AF,PF,CF}
module cmpxchg_flag_calc
    import cmpxchg_mem_seq_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] acc,
    input  logic [31:0] dest,
    output logic [5:0]  flags
);

    logic [31:0] mask;
    logic [31:0] diff;
    logic [32:0] sub;
    logic        acc_msb;
    logic        dest_msb;
    logic        diff_msb;

    always_comb begin
        mask = size_mask(size);
        // Operands are masked to size so bit 32 of the wide subtract is the size-width borrow.
        sub  = {1'b0, acc & mask} - {1'b0, dest & mask};
        diff = sub[31:0] & mask;
        case (size)
            SZ8: begin
                acc_msb  = acc[7];
                dest_msb = dest[7];
                diff_msb = diff[7];
            end
            SZ16: begin
                acc_msb  = acc[15];
                dest_msb = dest[15];
                diff_msb = diff[15];
            end
            default: begin
                acc_msb  = acc[31];
                dest_msb = dest[31];
                diff_msb = diff[31];
            end
        endcase
        flags          = '0;
        flags[FLAG_CF] = sub[32];
        flags[FLAG_PF] = ~^diff[7:0];
        flags[FLAG_AF] = acc[3:0] < dest[3:0];
        flags[FLAG_ZF] = diff == 32'd0;
        flags[FLAG_SF] = diff_msb;
        flags[FLAG_OF] = (acc_msb != dest_msb) & (diff_msb != acc_msb);
    end

endmodule

// File: rtl/cmpxchg_mem_seq.sv
// rtl/cmpxchg_mem_seq.sv - locked read/compare/write sequencer for memory-destination CMPXCHG
module cmpxchg_mem_seq
    import cmpxchg_mem_seq_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst_n,
    cmpxchg_mem_seq_if.slave bus
);

    state_t          state;
    state_t          state_nx;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   src_q;
    logic [DW-1:0]   acc_q;
    logic [DW-1:0]   dest_q;
    logic [DW-1:0]   acc_out_q;
    logic [5:0]      flags_q;
    logic            fault_q;
    logic            illegal;
    logic [5:0]      flags_nx;
    logic [DW-1:0]   acc_res;
    logic [DW-1:0]   wsel;
    logic [DW-1:0]   wdata;

    cmpxchg_flag_calc u_flag_calc (
        .size  (size_q),
        .acc   (acc_q),
        .dest  (dest_q),
        .flags (flags_nx)
    );

    assign illegal = is_illegal(size_q, addr_q[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.cmd_valid)     state_nx = S_CHECK;
            S_CHECK:   state_nx = illegal ? S_DONE : S_RD_REQ;
            S_RD_REQ:  if (bus.mem_req_ready) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (bus.mem_rsp_valid) state_nx = S_CMP;
            S_CMP:     state_nx = S_WR_REQ;
            S_WR_REQ:  if (bus.mem_req_ready) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q    <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            acc_q     <= '0;
            dest_q    <= '0;
            acc_out_q <= '0;
            flags_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    size_q  <= bus.cmd_size;
                    addr_q  <= bus.cmd_addr;
                    src_q   <= bus.cmd_src;
                    acc_q   <= bus.cmd_acc;
                    fault_q <= 1'b0;
                end
                S_CHECK: if (illegal) begin
                    fault_q   <= 1'b1;
                    acc_out_q <= acc_q;
                    flags_q   <= '0;
                end
                S_RD_WAIT: if (bus.mem_rsp_valid)
                    dest_q <= (bus.mem_rsp_rdata >> {addr_q[1:0], 3'b000}) & size_mask(size_q);
                S_CMP: begin
                    flags_q   <= flags_nx;
                    acc_out_q <= acc_res;
                end
                default: ;
            endcase
        end
    end

    // Mismatch loads DEST into the accumulator; untouched upper bits keep the old accumulator.
    always_comb begin
        acc_res = acc_q;
        if (!flags_nx[FLAG_ZF]) begin
            case (size_q)
                SZ8:     acc_res = {acc_q[31:8], dest_q[7:0]};
                SZ16:    acc_res = {acc_q[31:16], dest_q[15:0]};
                default: acc_res = dest_q;
            endcase
        end
    end

    // Locked semantics always write: SRC on match, original DEST otherwise.
    always_comb begin
        wsel = flags_q[FLAG_ZF] ? src_q : dest_q;
        case (size_q)
            SZ8:     wdata = {4{wsel[7:0]}};
            SZ16:    wdata = {2{wsel[15:0]}};
            default: wdata = wsel;
        endcase
    end

    assign bus.cmd_ready     = state == S_IDLE;
    assign bus.mem_req_valid = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign bus.mem_req_we    = state == S_WR_REQ;
    assign bus.mem_req_addr  = {addr_q[AW-1:2], 2'b00};
    assign bus.mem_req_be    = lane_be(size_q, addr_q[1:0]);
    assign bus.mem_req_wdata = wdata;
    assign bus.mem_lock      = (state == S_RD_REQ) || (state == S_RD_WAIT) ||
                               (state == S_CMP) || (state == S_WR_REQ);
    assign bus.done_valid    = state == S_DONE;
    assign bus.fault         = (state == S_DONE) && fault_q;
    assign bus.acc_out       = acc_out_q;
    assign bus.flags_out     = flags_q;

endmodule

// File: tb/tb_cmpxchg_mem_seq.sv
// tb/tb_cmpxchg_mem_seq.sv - directed bench for the memory-form CMPXCHG sequencer
module tb_cmpxchg_mem_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmpxchg_mem_seq_if #(.AW(32)) bus();

    cmpxchg_mem_seq #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          r_cycles, r_rd_cnt, r_wr_cnt, r_lock_ever, r_lock_err, r_stab_err, r_ready_err;
    int          r_timeout, r_done_len_err;
    logic [31:0] r_wdata, r_wr_addr, r_rd_addr, r_acc;
    logic [3:0]  r_be, r_rd_be;
    logic [5:0]  r_flags;
    logic        r_fault;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] src,
                           input logic [31:0] acc, input logic [31:0] rdata,
                           input int rd_stall, input int wr_stall, input int rsp_dly);
        int cyc, stall, rsp_cnt, lim;
        logic in_req, rsp_pend, wr_acc;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        logic        s_we;
        {r_rd_cnt, r_wr_cnt, r_lock_ever, r_lock_err, r_stab_err, r_ready_err} = '0;
        {r_timeout, r_done_len_err} = '0;
        {r_wdata, r_wr_addr, r_rd_addr, r_be, r_rd_be} = '0;
        {in_req, rsp_pend, wr_acc, stall, rsp_cnt} = '0;
        {s_addr, s_wdata, s_be, s_we} = '0;
        @(negedge clk);
        bus.cmd_size  = sz;
        bus.cmd_addr  = addr;
        bus.cmd_src   = src;
        bus.cmd_acc   = acc;
        bus.cmd_valid = 1'b1;
        if (!bus.cmd_ready) r_ready_err++;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 80 && !bus.done_valid) begin
            if (bus.cmd_ready) r_ready_err++;
            if (bus.mem_lock) r_lock_ever = 1;
            if (r_lock_ever != 0 && !wr_acc && !bus.mem_lock) r_lock_err++;
            bus.mem_rsp_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_cnt == rsp_dly) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_rdata = rdata;
                    rsp_pend = 1'b0;
                end else rsp_cnt++;
            end
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                if (!in_req) begin
                    in_req  = 1'b1;
                    stall   = 0;
                    s_addr  = bus.mem_req_addr;
                    s_be    = bus.mem_req_be;
                    s_we    = bus.mem_req_we;
                    s_wdata = bus.mem_req_wdata;
                end else if (s_addr !== bus.mem_req_addr || s_be !== bus.mem_req_be ||
                             s_we !== bus.mem_req_we ||
                             (s_we && s_wdata !== bus.mem_req_wdata)) r_stab_err++;
                lim = bus.mem_req_we ? wr_stall : rd_stall;
                if (stall >= lim) begin
                    bus.mem_req_ready = 1'b1;
                    in_req = 1'b0;
                    if (bus.mem_req_we) begin
                        r_wr_cnt++;
                        r_wdata   = bus.mem_req_wdata;
                        r_be      = bus.mem_req_be;
                        r_wr_addr = bus.mem_req_addr;
                        wr_acc    = 1'b1;
                    end else begin
                        r_rd_cnt++;
                        r_rd_addr = bus.mem_req_addr;
                        r_rd_be   = bus.mem_req_be;
                        rsp_pend  = 1'b1;
                        rsp_cnt   = 0;
                    end
                end else stall++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (!bus.done_valid) r_timeout = 1;
        if (bus.mem_lock) r_lock_err++;
        r_cycles = cyc;
        r_acc    = bus.acc_out;
        r_flags  = bus.flags_out;
        r_fault  = bus.fault;
        @(negedge clk);
        if (bus.done_valid || bus.fault) r_done_len_err++;
        if (bus.acc_out !== r_acc) r_done_len_err++;
    endtask

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_size      = '0;
        bus.cmd_addr      = '0;
        bus.cmd_src       = '0;
        bus.cmd_acc       = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;

        @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_req_valid", bus.mem_req_valid, 0);
        check_eq("rst_lock", bus.mem_lock, 0);
        check_eq("rst_done", bus.done_valid, 0);
        check_eq("rst_fault", bus.fault, 0);
        check_eq("rst_acc_out", bus.acc_out, 0);
        check_eq("rst_flags", bus.flags_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32b equal, zero-wait memory
        run_cmd(2'd2, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 0, 0, 0);
        check_eq("eq32_timeout", r_timeout, 0);
        check_eq("eq32_latency", r_cycles, 6);
        check_eq("eq32_rd_addr", r_rd_addr, 32'h100);
        check_eq("eq32_wdata", r_wdata, 32'hDEAD_BEEF);
        check_eq("eq32_be", r_be, 4'b1111);
        check_eq("eq32_flags", r_flags, 6'b001010);
        check_eq("eq32_acc", r_acc, 32'h1234_5678);
        check_eq("eq32_fault", r_fault, 0);
        check_eq("eq32_pulse", r_done_len_err, 0);

        // 8b not equal, lane 2
        run_cmd(2'd0, 32'h202, 32'h0000_0011, 32'hFFFF_FF60, 32'hAA55_0000, 0, 0, 0);
        check_eq("ne8_be", r_be, 4'b0100);
        check_eq("ne8_rd_be", r_rd_be, 4'b0100);
        check_eq("ne8_wbyte", {24'd0, r_wdata[23:16]}, 32'h55);
        check_eq("ne8_wr_addr", r_wr_addr, 32'h200);
        check_eq("ne8_flags", r_flags, 6'b000100);
        check_eq("ne8_acc", r_acc, 32'hFFFF_FF55);

        // 8b equal, lane 3
        run_cmd(2'd0, 32'h603, 32'h0000_00AB, 32'h1234_567F, 32'h7F00_0000, 0, 0, 0);
        check_eq("eq8_be", r_be, 4'b1000);
        check_eq("eq8_wbyte", {24'd0, r_wdata[31:24]}, 32'hAB);
        check_eq("eq8_flags", r_flags, 6'b001010);
        check_eq("eq8_acc", r_acc, 32'h1234_567F);

        // 16b borrow, upper half
        run_cmd(2'd1, 32'h302, 32'h0000_4321, 32'h0000_7FFF, 32'h8000_1234, 0, 0, 0);
        check_eq("b16_be", r_be, 4'b1100);
        check_eq("b16_whalf", {16'd0, r_wdata[31:16]}, 32'h8000);
        check_eq("b16_flags", r_flags, 6'b110011);
        check_eq("b16_acc", r_acc, 32'h0000_8000);

        // misaligned 32b and illegal size
        run_cmd(2'd2, 32'h401, 32'h5555_5555, 32'hCAFE_0001, 32'h0, 0, 0, 0);
        check_eq("mis_rd_cnt", r_rd_cnt + r_wr_cnt, 0);
        check_eq("mis_lock", r_lock_ever, 0);
        check_eq("mis_fault", r_fault, 1);
        check_eq("mis_acc", r_acc, 32'hCAFE_0001);
        check_eq("mis_flags", r_flags, 0);
        check_eq("mis_latency", r_cycles, 2);
        check_eq("mis_pulse", r_done_len_err, 0);
        run_cmd(2'd3, 32'h800, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
        check_eq("sz3_mem", r_rd_cnt + r_wr_cnt, 0);
        check_eq("sz3_fault", r_fault, 1);
        check_eq("sz3_acc", r_acc, 32'h0BAD_F00D);

        // backpressure on both requests plus delayed response
        run_cmd(2'd2, 32'h500, 32'h1111_2222, 32'h0000_0001, 32'hCAFE_F00D, 3, 3, 4);
        check_eq("bp_timeout", r_timeout, 0);
        check_eq("bp_latency", r_cycles, 16);
        check_eq("bp_stable", r_stab_err, 0);
        check_eq("bp_lock", r_lock_err, 0);
        check_eq("bp_ready", r_ready_err, 0);
        check_eq("bp_counts", r_rd_cnt * 16 + r_wr_cnt, 32'h11);
        check_eq("bp_wdata", r_wdata, 32'hCAFE_F00D);
        check_eq("bp_flags", r_flags, 6'b000101);
        check_eq("bp_acc", r_acc, 32'hCAFE_F00D);

        // asynchronous reset while waiting for read data
        @(negedge clk);
        bus.cmd_size  = 2'd2;
        bus.cmd_addr  = 32'h700;
        bus.cmd_src   = 32'h7777_7777;
        bus.cmd_acc   = 32'h0000_0700;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_rd_req", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check_eq("rw_lock", bus.mem_lock, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rw_cmd_ready", bus.cmd_ready, 1);
        check_eq("rw_lock_drop", bus.mem_lock, 0);
        check_eq("rw_req_valid", bus.mem_req_valid, 0);
        check_eq("rw_acc_out", bus.acc_out, 0);
        check_eq("rw_flags", bus.flags_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_0700;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 5; i++) begin
                if (bus.mem_req_valid || bus.mem_lock || bus.done_valid) stray++;
                @(negedge clk);
            end
            check_eq("rw_no_stray", stray, 0);
        end
        run_cmd(2'd2, 32'h700, 32'h7777_7777, 32'h0000_0700, 32'h0000_0700, 0, 0, 0);
        check_eq("rw_next_latency", r_cycles, 6);
        check_eq("rw_next_wdata", r_wdata, 32'h7777_7777);
        check_eq("rw_next_acc", r_acc, 32'h0000_0700);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
